// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and optional perf counters (PIPE_STAGE_PERF_EN).
// Latency: 1 cycle from accept in EMPTY to out_valid; sustains 1 bundle/cycle while out_ready=1.
// Backpressure: in_ready is a registered decode of the next state, so there is no combinational path from out_ready.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                accept;
  logic                fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = 2'(state_q);
  assign accept    = in_valid & in_ready_q;
  assign fire      = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
          state_d     = ST_TWO;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Squash kills control only; data payload is left in place to avoid wide enables.
    if (flush) begin
      state_d     = ST_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
    if (!out_valid && (bubble_q != {CNT_W{1'b1}}))
      bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed vector table, hand sequences and a queue-based random reference model.
module tb_pipe_stage_reg;
  localparam int DATA_W = 128;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } item_t;

  typedef struct {
    logic              iv;
    logic [CTRL_W-1:0] ictrl;
    logic [DATA_W-1:0] idata;
    logic              ordy;
    logic              fl;
    logic              e_vld;
    logic              chk_ctrl;
    logic [CTRL_W-1:0] e_ctrl;
    logic              chk_data;
    logic [DATA_W-1:0] e_data;
    logic [1:0]        e_occ;
    logic              e_rdy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the stage is a FIFO of depth 2 whose head is presented downstream.
  item_t q[$];
  bit    ctrl_zero;
  int    stall_m, bubble_m;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ctrl_zero = 1'b1;
    stall_m = 0;
    bubble_m = 0;
  endtask

  task automatic model_edge();
    bit acc, fire;
    acc  = in_valid && (q.size() < 2);
    fire = (q.size() > 0) && out_ready;
    if ((q.size() > 0) && !out_ready && stall_m < CNT_MAX) stall_m++;
    if ((q.size() == 0) && bubble_m < CNT_MAX) bubble_m++;
    if (flush) begin
      q.delete();
      ctrl_zero = 1'b1;
    end else begin
      if (fire) void'(q.pop_front());
      if (acc) begin
        item_t it;
        it.ctrl = in_ctrl;
        it.data = in_data;
        q.push_back(it);
        ctrl_zero = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    check("m_out_valid", DATA_W'(out_valid), DATA_W'(q.size() != 0));
    check("m_occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
    check("m_in_ready", DATA_W'(in_ready), DATA_W'(q.size() < 2));
    if (q.size() != 0) begin
      check("m_out_data", out_data, q[0].data);
      check("m_out_ctrl", DATA_W'(out_ctrl), DATA_W'(q[0].ctrl));
    end else if (ctrl_zero) begin
      check("m_ctrl_cleared", DATA_W'(out_ctrl), '0);
    end
`ifdef PIPE_STAGE_PERF_EN
    check("m_stall_cnt", DATA_W'(stall_cnt), DATA_W'(stall_m));
    check("m_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(bubble_m));
`else
    check("m_stall_cnt_tied", DATA_W'(stall_cnt), '0);
    check("m_bubble_cnt_tied", DATA_W'(bubble_cnt), '0);
`endif
  endtask

  // Drive after a falling edge, clock once, then sample on the next falling edge.
  task automatic step(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                      input logic ordy, input logic fl);
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic iv, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                              input logic ordy, input logic fl, input logic ev, input logic cc,
                              input logic [CTRL_W-1:0] ec, input logic cd, input logic [DATA_W-1:0] ed,
                              input logic [1:0] eo, input logic er);
    vec_t v;
    v.iv = iv; v.ictrl = c; v.idata = d; v.ordy = ordy; v.fl = fl;
    v.e_vld = ev; v.chk_ctrl = cc; v.e_ctrl = ec; v.chk_data = cd; v.e_data = ed;
    v.e_occ = eo; v.e_rdy = er;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    // Backpressure then drain, then flush while full with a colliding input.
    vecs[0] = mk(1, 16'hFFFF, 'hA, 0, 0, 1, 1, 16'hFFFF, 1, 'hA, 2'd1, 1);
    vecs[1] = mk(1, 16'hFFFF, 'hB, 0, 0, 1, 1, 16'hFFFF, 1, 'hA, 2'd2, 0);
    vecs[2] = mk(0, 16'h0000, 'h0, 1, 0, 1, 1, 16'hFFFF, 1, 'hB, 2'd1, 1);
    vecs[3] = mk(0, 16'h0000, 'h0, 1, 0, 0, 0, 16'h0000, 0, 'h0, 2'd0, 1);
    vecs[4] = mk(1, 16'hFFFF, 'hA, 0, 0, 1, 1, 16'hFFFF, 1, 'hA, 2'd1, 1);
    vecs[5] = mk(1, 16'hFFFF, 'hB, 0, 0, 1, 1, 16'hFFFF, 1, 'hA, 2'd2, 0);
    vecs[6] = mk(1, 16'h1234, 'hC, 0, 1, 0, 1, 16'h0000, 1, 'hA, 2'd0, 1);
    vecs[7] = mk(0, 16'h0000, 'h0, 1, 0, 0, 1, 16'h0000, 1, 'hA, 2'd0, 1);

    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("rst_out_valid", DATA_W'(out_valid), '0);
    check("rst_out_ctrl", DATA_W'(out_ctrl), '0);
    check("rst_out_data", out_data, '0);
    check("rst_occupancy", DATA_W'(occupancy), '0);
    check("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
    for (int k = 1; k <= 3; k++) begin
      step(0, '0, '0, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
      check("idle_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(k));
`else
      check("idle_bubble_cnt", DATA_W'(bubble_cnt), '0);
`endif
      model_check();
    end

    // Streaming 0..9 at full rate.
    for (int i = 0; i < 10; i++) begin
      step(1, 16'h0001, DATA_W'(i), 1, 0);
      check("stream_data", out_data, DATA_W'(i));
      check("stream_occ", DATA_W'(occupancy), DATA_W'(1));
      model_check();
    end
    step(0, '0, '0, 1, 0);
    model_check();

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].iv, vecs[i].ictrl, vecs[i].idata, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d_out_valid", i), DATA_W'(out_valid), DATA_W'(vecs[i].e_vld));
      check($sformatf("vec%0d_occupancy", i), DATA_W'(occupancy), DATA_W'(vecs[i].e_occ));
      check($sformatf("vec%0d_in_ready", i), DATA_W'(in_ready), DATA_W'(vecs[i].e_rdy));
      if (vecs[i].chk_ctrl) check($sformatf("vec%0d_out_ctrl", i), DATA_W'(out_ctrl), DATA_W'(vecs[i].e_ctrl));
      if (vecs[i].chk_data) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
      model_check();
    end

    // Async reset between edges while full.
    step(1, 16'hFFFF, 'h11, 0, 0);
    step(1, 16'hFFFF, 'h22, 0, 0);
    check("pre_arst_occ", DATA_W'(occupancy), DATA_W'(2));
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", DATA_W'(out_valid), '0);
    check("arst_out_ctrl", DATA_W'(out_ctrl), '0);
    check("arst_occupancy", DATA_W'(occupancy), '0);
    model_reset();
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_check();

    // Hold one item under backpressure long enough to saturate the stall counter.
    step(1, 16'h00AA, 'h55, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, '0, '0, 0, 0);
      model_check();
    end
`ifdef PIPE_STAGE_PERF_EN
    check("stall_saturated", DATA_W'(stall_cnt), DATA_W'(CNT_MAX));
`else
    check("stall_tied", DATA_W'(stall_cnt), '0);
`endif
    check("stall_hold_data", out_data, DATA_W'('h55));

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 3) != 0 ? 1 : 0) & 1'($urandom_range(0, 1) | (i % 3)),
           1'($urandom_range(0, 19) == 0));
      model_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: simulation did not finish within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers. Carries a CTRL_W control bundle and a DATA_W data bundle between any two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer. Sustains full throughput with a registered in_ready.
- Adds synchronous flush for branch/exception squash; flush clears the control bundle.

Parameters:
- DATA_W, 128, width of data bundle (operands, immediates, PC); never cleared by flush.
- CTRL_W, 16, width of control bundle (regwrite, memread, ALUop, ...); forced to 0 on reset and flush.
- CNT_W, 16, width of performance counters (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash, highest priority after reset.
- in_valid  in  1  upstream has a bundle.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  bundle presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control bundle to downstream.
- out_data  out  DATA_W  data bundle to downstream.
- occupancy  out  2  entries held (0, 1 or 2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0.

Behaviour:
- Storage is a main register (drives outputs directly) plus a skid register. The state is EMPTY, ONE or TWO; occupancy encodes it as 0, 1 or 2.
- Accept means in_valid & in_ready. Fire means out_valid & out_ready.
- in_ready = 1 in EMPTY and ONE, 0 in TWO. in_ready is a registered decode of the next state; no combinational path from out_ready.
- out_valid = 1 in ONE and TWO.
- Reset (rst=0, async) sets:
  - state to EMPTY; in_ready=1 after release.
  - out_valid=0, out_ctrl=0, out_data=0.
  - skid register=0; counters=0.
- EMPTY:
  - accept: main <= in; go to ONE.
  - otherwise stay in EMPTY.
- ONE:
  - accept & fire: main <= in; stay in ONE.
  - accept only: skid <= in; go to TWO.
  - fire only: go to EMPTY.
  - neither: stay in ONE.
- TWO (no accept possible):
  - fire: main <= skid; go to ONE.
  - otherwise stay in TWO.
- Flush (flush=1 at a clock edge):
  - state goes to EMPTY; out_valid=0; out_ctrl=0; skid ctrl=0.
  - Data registers hold their values.
  - An input accepted in the same cycle is discarded.
  - Any fire in the flush cycle still counts downstream.
- Latency: accept in EMPTY gives out_valid=1 on the next cycle.
- Throughput: 1 bundle/cycle while out_ready=1.
- Ordering: strictly FIFO, with no duplication or loss except by flush.
- Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data do not change.
- Release of rst is assumed synchronised externally; behaviour depends only on the first rising edge after release.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0.
  - Both saturate at 2^CNT_W-1.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: stall_cnt and bubble_cnt are tied to 0 and no counter flops are synthesised. Ports remain present.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then released → out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; bubble_cnt counts 1,2,3 after release (PERF_EN).
- Streaming: in_valid=1 and out_ready=1 constant, in_data=0..9 → out_data=0..9 on consecutive cycles starting 1 cycle after first accept; occupancy stays 1.
- Backpressure: send 0xA, 0xB with out_ready=0 → occupancy=2 and in_ready=0; out_data holds 0xA. Raise out_ready for 2 cycles → 0xA then 0xB delivered; in_ready=1 one cycle after first fire.
- Flush in TWO: hold 0xA/0xB (ctrl=16'hFFFF), assert flush with in_valid=1 and in_data=0xC → next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xC never appears.
- Async reset mid-stream: drop rst between clock edges while occupancy=2 → out_valid=0, out_ctrl=0 immediately, before the next edge.
- Counter saturation (CNT_W=4, PERF_EN): out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15 and holds.
